// File: rtl/rw_buffer_pkg.sv
// rw_buffer shared definitions.
// Defaults, op encodings and occupancy width helper.
package rw_buffer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Occupancy spans 0..DEPTH, so one bit wider than the index.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int OCC_W_DEF = occ_w(DEPTH_DEF);

endpackage

// File: rtl/rw_buffer_wrap_ptr.sv
// Wrapping pointer: index bits plus a wrap bit.
// Rolls over naturally at 2^W.
module wrap_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Advance by one on each enabled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/rw_buffer.sv
// Circular buffer behind the read/write controller.
// One read or write per controller fire.
module rw_buffer
  import rw_buffer_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int OCC_W  = occ_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] din,
  input  logic              valid,
  input  logic              count_pointer,
  output logic              check,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic [OCC_W-1:0]  count,
  output logic              err
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [OCC_W-1:0]  wptr;
  logic [OCC_W-1:0]  rptr;
  logic              req;
  logic              fire;
  logic              wr_fire;
  logic              rd_fire;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign count = wptr - rptr;
  assign check = (wr_req == OP_WRITE) ? !full : !empty;

  assign req     = valid & count_pointer;
  assign fire    = req & check;
  assign wr_fire = fire & (wr_req == OP_WRITE);
  assign rd_fire = fire & (wr_req == OP_READ);

  wrap_ptr #(.W(OCC_W)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_fire),
    .ptr (wptr)
  );

  wrap_ptr #(.W(OCC_W)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_fire),
    .ptr (rptr)
  );

  // Storage; contents survive reset since empty guards stale reads.
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wptr[ADDR_W-1:0]] <= din;
  end

  // Registered read data with a one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_fire;
      if (rd_fire)
        dout <= mem[rptr[ADDR_W-1:0]];
    end
  end

  // Sticky flag for a request the buffer could not honour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (req && !check)
      err <= 1'b1;
  end

endmodule

// File: tb/tb_rw_buffer.sv
// Self-checking bench for rw_buffer.
// Queue model plus directed literal checks.
module tb_rw_buffer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] din = '0;
  logic       valid = 1'b0;
  logic       count_pointer = 1'b0;
  logic       check;
  logic [7:0] dout;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       err;

  int passed = 0;
  int total  = 0;
  int maxc   = 0;
  bit track  = 1'b0;

  rw_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .wr_req        (wr_req),
    .din           (din),
    .valid         (valid),
    .count_pointer (count_pointer),
    .check         (check),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Model: FIFO queue of accepted words plus output registers.
  logic [7:0] q [$];
  logic [7:0] m_dout = '0;
  bit         m_dv   = 1'b0;
  bit         m_err  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_dv = 1'b0;
      if (valid && count_pointer) begin
        if (wr_req && q.size() < DEPTH) begin
          q.push_back(din);
        end else if (!wr_req && q.size() > 0) begin
          m_dout = q.pop_front();
          m_dv   = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // Every mid-cycle: DUT outputs against the model.
  always @(negedge clk) begin
    int sz;
    sz = q.size();
    chk("count", int'(count), sz);
    chk("empty", int'(empty), int'(sz == 0));
    chk("full", int'(full), int'(sz == DEPTH));
    chk("check", int'(check),
        wr_req ? int'(sz < DEPTH) : int'(sz > 0));
    chk("dout", int'(dout), int'(m_dout));
    chk("dout_valid", int'(dout_valid), int'(m_dv));
    chk("err", int'(err), int'(m_err));
    if (track && int'(count) > maxc) maxc = int'(count);
  end

  task automatic op(input bit wr, input logic [7:0] d);
    @(posedge clk); #1;
    wr_req = wr; din = d; valid = 1'b1; count_pointer = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; count_pointer = 1'b0;
  endtask

  task automatic rd_expect(input logic [7:0] d, input string nm);
    op(1'b0, 8'h00);
    @(negedge clk);
    chk({nm, "_dout"}, int'(dout), int'(d));
    chk({nm, "_dv"}, int'(dout_valid), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #12 rst = 1'b0;

    // Reset mid-stream, no clock edge before the checks.
    op(1'b1, 8'h01);
    op(1'b1, 8'h02);
    op(1'b0, 8'h00);
    @(posedge clk); #2;
    wr_req = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_dv", int'(dout_valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_check_wr", int'(check), 1);
    wr_req = 1'b0;
    #1;
    chk("rst_check_rd", int'(check), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill 0x11..0x88.
    for (int i = 1; i <= 8; i++) begin
      op(1'b1, 8'(i * 8'h11));
      @(negedge clk);
      chk("fill_count", int'(count), i);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_check", int'(check), 0);

    // Drain in order.
    for (int i = 1; i <= 8; i++)
      rd_expect(8'(i * 8'h11), "drain");
    @(negedge clk);
    chk("drain_empty", int'(empty), 1);
    chk("drain_dv_low", int'(dout_valid), 0);

    // Wrap-around across index 7 -> 0.
    do_reset();
    track = 1'b1;
    maxc = 0;
    for (int i = 0; i < 5; i++) op(1'b1, 8'(8'hA0 + i));
    for (int i = 0; i < 5; i++) rd_expect(8'(8'hA0 + i), "wrap1");
    for (int i = 0; i < 6; i++) op(1'b1, 8'(8'hB0 + i));
    for (int i = 0; i < 6; i++) rd_expect(8'(8'hB0 + i), "wrap2");
    track = 1'b0;
    chk("wrap_maxcount", maxc, 6);
    chk("wrap_empty", int'(empty), 1);

    // Overflow.
    do_reset();
    for (int i = 0; i < 8; i++) op(1'b1, 8'(8'hC0 + i));
    op(1'b1, 8'hEE);
    @(negedge clk);
    chk("ovf_count", int'(count), 8);
    chk("ovf_full", int'(full), 1);
    chk("ovf_err", int'(err), 1);
    rd_expect(8'hC0, "ovf_head");

    // Underflow after reset.
    do_reset();
    op(1'b0, 8'h00);
    @(negedge clk);
    chk("udf_dout", int'(dout), 0);
    chk("udf_dv", int'(dout_valid), 0);
    chk("udf_err", int'(err), 1);
    chk("udf_count", int'(count), 0);

    // Partial strobes.
    do_reset();
    op(1'b1, 8'h5A);
    @(posedge clk); #1;
    wr_req = 1'b1; din = 8'h77; valid = 1'b1; count_pointer = 1'b0;
    @(posedge clk); #1;
    wr_req = 1'b0; valid = 1'b0; count_pointer = 1'b1;
    @(posedge clk); #1;
    count_pointer = 1'b0;
    @(negedge clk);
    chk("part_count", int'(count), 1);
    chk("part_err", int'(err), 0);
    chk("part_dv", int'(dout_valid), 0);
    chk("part_dout", int'(dout), 0);
    rd_expect(8'h5A, "part_data");

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
